// File: rtl/pipeline_decode.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and a
// saturating stall counter.
module pipeline_decode #(
    parameter int          DATA_W   = 64,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     valid_id,
    input  logic                     MemWrite_id,
    input  logic                     MemToReg_id,
    input  logic                     RegDest_id,
    input  logic                     RegWrite_id,
    input  logic                     ALUSrc_id,
    input  logic [2:0]               ALUOp_id,
    input  logic [4:0]               Rn_id,
    input  logic [4:0]               Rm_id,
    input  logic [4:0]               Rd_id,
    input  logic signed [DATA_W-1:0] Da_id,
    input  logic signed [DATA_W-1:0] Db_id,
    input  logic signed [DATA_W-1:0] Imm_id,
    input  logic                     flush,

    output logic                     valid_ex,
    output logic                     MemWrite_ex,
    output logic                     MemToReg_ex,
    output logic                     RegDest_ex,
    output logic                     RegWrite_ex,
    output logic                     ALUSrc_ex,
    output logic [2:0]               ALUOp_ex,
    output logic [4:0]               Rn_ex,
    output logic [4:0]               Rm_ex,
    output logic [4:0]               Rd_ex,
    output logic signed [DATA_W-1:0] Da_ex,
    output logic signed [DATA_W-1:0] Db_ex,
    output logic signed [DATA_W-1:0] Imm_ex,
    output logic                     stall,
    output logic [15:0]              stall_count
);

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] BUBBLE = 1'b1;
    localparam logic [4:0] ZERO_ADDR = 5'(ZERO_REG);

    logic [0:0] state;
    logic       hz;
    logic       loadEn;

    function automatic logic [15:0] satInc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    // Hazard: EX holds a load whose destination is read by the ID instruction.
    always_comb begin
        hz = valid_ex & MemToReg_ex & RegWrite_ex & (Rd_ex != ZERO_ADDR) & valid_id &
             ((Rd_ex == Rn_id) | (~ALUSrc_id & (Rd_ex == Rm_id)));
        stall  = hz & ~flush & (state == RUN);
        loadEn = ~reset & ~flush & ~stall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            stall_count <= 16'd0;
        end else if (flush) begin
            state <= RUN;
        end else if (stall) begin
            state       <= BUBBLE;
            stall_count <= satInc(stall_count);
        end else begin
            state <= RUN;
        end
    end

    // ID -> EX boundary: load on a normal cycle, otherwise everything clears.
    always_ff @(posedge clk) begin
        if (loadEn) begin
            valid_ex    <= valid_id;
            MemWrite_ex <= MemWrite_id;
            MemToReg_ex <= MemToReg_id;
            RegDest_ex  <= RegDest_id;
            RegWrite_ex <= RegWrite_id;
            ALUSrc_ex   <= ALUSrc_id;
            ALUOp_ex    <= ALUOp_id;
            Rn_ex       <= Rn_id;
            Rm_ex       <= Rm_id;
            Rd_ex       <= Rd_id;
            Da_ex       <= Da_id;
            Db_ex       <= Db_id;
            Imm_ex      <= Imm_id;
        end else begin
            valid_ex    <= 1'b0;
            MemWrite_ex <= 1'b0;
            MemToReg_ex <= 1'b0;
            RegDest_ex  <= 1'b0;
            RegWrite_ex <= 1'b0;
            ALUSrc_ex   <= 1'b0;
            ALUOp_ex    <= 3'd0;
            Rn_ex       <= 5'd0;
            Rm_ex       <= 5'd0;
            Rd_ex       <= 5'd0;
            Da_ex       <= '0;
            Db_ex       <= '0;
            Imm_ex      <= '0;
        end
    end

endmodule

// File: tb/tb_pipeline_decode.sv
// Directed bench for pipeline_decode: expected EX records are queued at issue time
// and a negedge monitor pops and compares them whenever valid_ex is high.
module tb_pipeline_decode;

    typedef struct packed {
        logic        memWrite;
        logic        memToReg;
        logic        regDest;
        logic        regWrite;
        logic        aluSrc;
        logic [2:0]  aluOp;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [4:0]  rd;
        logic [63:0] da;
        logic [63:0] db;
        logic [63:0] imm;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    logic valid_id;
    logic flush;
    rec_t idRec;
    rec_t exOut;

    logic        MemWrite_ex, MemToReg_ex, RegDest_ex, RegWrite_ex, ALUSrc_ex, valid_ex;
    logic [2:0]  ALUOp_ex;
    logic [4:0]  Rn_ex, Rm_ex, Rd_ex;
    logic [63:0] Da_ex, Db_ex, Imm_ex;
    logic        stall;
    logic [15:0] stall_count;

    rec_t expQ[$];
    int   vectors = 0;
    int   errors  = 0;
    logic [15:0] expCnt;

    always #5 clk = ~clk;

    pipeline_decode #(.DATA_W(64), .ZERO_REG(31)) dut (
        .clk(clk), .reset(reset), .valid_id(valid_id),
        .MemWrite_id(idRec.memWrite), .MemToReg_id(idRec.memToReg), .RegDest_id(idRec.regDest),
        .RegWrite_id(idRec.regWrite), .ALUSrc_id(idRec.aluSrc), .ALUOp_id(idRec.aluOp),
        .Rn_id(idRec.rn), .Rm_id(idRec.rm), .Rd_id(idRec.rd),
        .Da_id(idRec.da), .Db_id(idRec.db), .Imm_id(idRec.imm), .flush(flush),
        .valid_ex(valid_ex), .MemWrite_ex(MemWrite_ex), .MemToReg_ex(MemToReg_ex),
        .RegDest_ex(RegDest_ex), .RegWrite_ex(RegWrite_ex), .ALUSrc_ex(ALUSrc_ex),
        .ALUOp_ex(ALUOp_ex), .Rn_ex(Rn_ex), .Rm_ex(Rm_ex), .Rd_ex(Rd_ex),
        .Da_ex(Da_ex), .Db_ex(Db_ex), .Imm_ex(Imm_ex),
        .stall(stall), .stall_count(stall_count)
    );

    assign exOut = {MemWrite_ex, MemToReg_ex, RegDest_ex, RegWrite_ex, ALUSrc_ex, ALUOp_ex,
                    Rn_ex, Rm_ex, Rd_ex, Da_ex, Db_ex, Imm_ex};

    function automatic rec_t mk(input logic mw, input logic m2r, input logic rdst,
                                input logic rw, input logic as, input logic [2:0] op,
                                input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                                input logic [63:0] da, input logic [63:0] db,
                                input logic [63:0] imm);
        rec_t r;
        r.memWrite = mw;  r.memToReg = m2r; r.regDest = rdst; r.regWrite = rw;
        r.aluSrc   = as;  r.aluOp    = op;  r.rn = rn; r.rm = rm; r.rd = rd;
        r.da = da; r.db = db; r.imm = imm;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic bubbleChk(input string nm);
        chk({nm, "_valid"}, {63'd0, valid_ex}, 64'd0);
        vectors++;
        if (exOut !== '0) begin
            errors++;
            $display("FAIL %s_fields got=%h required=0", nm, exOut);
        end
    endtask

    // Inputs are already driven; check stall, queue the expected load, advance one edge.
    task automatic cycle(input string nm, input logic expStall, input logic expPush);
        #1;
        chk({nm, "_stall"}, {63'd0, stall}, {63'd0, expStall});
        if (expPush) expQ.push_back(idRec);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (valid_ex === 1'b1) begin
            vectors++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL ex_unexpected got=%h required=none", exOut);
            end else begin
                rec_t e;
                e = expQ.pop_front();
                if (exOut !== e) begin
                    errors++;
                    $display("FAIL ex_fields got=%h required=%h", exOut, e);
                end
            end
        end
    end

    rec_t P, L, C, I, R, Z, ZC, N, L2;

    initial begin
        P  = mk(0, 0, 1, 1, 0, 3'd2, 5'd1, 5'd2, 5'd5, 64'h1234, 64'hABCD, 64'hFFFF_FFFF_FFFF_FFF8);
        L  = mk(0, 1, 0, 1, 1, 3'd0, 5'd4, 5'd6, 5'd3, 64'h100, 64'h0, 64'h8);
        C  = mk(0, 0, 1, 1, 0, 3'd1, 5'd3, 5'd9, 5'd10, 64'h77, 64'h88, 64'h0);
        I  = mk(0, 0, 0, 1, 1, 3'd3, 5'd7, 5'd3, 5'd12, 64'h5, 64'h6, 64'h10);
        R  = mk(1, 0, 0, 0, 0, 3'd4, 5'd7, 5'd3, 5'd13, 64'h9, 64'hA, 64'h0);
        Z  = mk(0, 1, 0, 1, 1, 3'd0, 5'd2, 5'd0, 5'd31, 64'h20, 64'h0, 64'h4);
        ZC = mk(0, 0, 1, 1, 0, 3'd5, 5'd31, 5'd31, 5'd14, 64'h1, 64'h2, 64'h0);
        N  = mk(0, 0, 1, 1, 0, 3'd6, 5'd19, 5'd2, 5'd15, 64'h3, 64'h4, 64'h0);
        L2 = mk(0, 1, 0, 1, 0, 3'd0, 5'd3, 5'd8, 5'd3, 64'hDEAD, 64'h0, 64'h18);

        reset = 1'b1; flush = 1'b0; valid_id = 1'b0; idRec = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bubbleChk("reset");
        chk("reset_cnt", {48'd0, stall_count}, 64'd0);
        reset = 1'b0;
        expCnt = 16'd0;

        // pass-through
        valid_id = 1'b1; idRec = P;
        cycle("pass", 0, 1);

        // load-use on Rn: one stall, one bubble, then the held instruction loads
        idRec = L;  cycle("ld1", 0, 1);
        idRec = C;  cycle("use1", 1, 0);
        bubbleChk("use1_bubble");
        expCnt = 16'd1;
        chk("use1_cnt", {48'd0, stall_count}, {48'd0, expCnt});
        cycle("use1_hold", 0, 1);
        chk("use1_cnt2", {48'd0, stall_count}, {48'd0, expCnt});

        // immediate form exempts Rm; register form on Rm stalls
        idRec = L;  cycle("ld2", 0, 1);
        idRec = I;  cycle("imm", 0, 1);
        idRec = L;  cycle("ld3", 0, 1);
        idRec = R;  cycle("rm_use", 1, 0);
        bubbleChk("rm_bubble");
        expCnt = 16'd2;
        chk("rm_cnt", {48'd0, stall_count}, {48'd0, expCnt});
        cycle("rm_hold", 0, 1);

        // zero register never stalls; near-miss address never stalls
        idRec = Z;  cycle("ldz", 0, 1);
        idRec = ZC; cycle("zuse", 0, 1);
        idRec = L;  cycle("ld4", 0, 1);
        idRec = N;  cycle("near", 0, 1);

        // invalid ID slot with matching address loads fields but no valid, no stall
        idRec = L;  cycle("ld5", 0, 1);
        valid_id = 1'b0; idRec = C;
        cycle("inv", 0, 0);
        chk("inv_valid", {63'd0, valid_ex}, 64'd0);
        chk("inv_rn", {59'd0, Rn_ex}, 64'd3);
        chk("inv_da", Da_ex, 64'h77);
        chk("inv_cnt", {48'd0, stall_count}, {48'd0, expCnt});

        // flush beats a hazard
        valid_id = 1'b1;
        idRec = L;  cycle("ld6", 0, 1);
        idRec = C;  flush = 1'b1;
        cycle("flush", 0, 0);
        bubbleChk("flush_bubble");
        chk("flush_cnt", {48'd0, stall_count}, {48'd0, expCnt});
        flush = 1'b0;
        cycle("after_flush", 0, 1);

        // reset while in BUBBLE with valid ID
        idRec = L;  cycle("ld7", 0, 1);
        idRec = C;  cycle("use7", 1, 0);
        expCnt = 16'd3;
        chk("use7_cnt", {48'd0, stall_count}, {48'd0, expCnt});
        reset = 1'b1;
        cycle("rst_mid", 0, 0);
        bubbleChk("rst_mid");
        chk("rst_mid_cnt", {48'd0, stall_count}, 64'd0);
        reset = 1'b0;
        idRec = L;  cycle("ld8", 0, 1);
        idRec = C;  cycle("use8", 1, 0);
        expCnt = 16'd1;
        chk("use8_cnt", {48'd0, stall_count}, {48'd0, expCnt});

        // saturation: a self-dependent load re-stalls every other cycle
        idRec = L2; cycle("sat_ld", 0, 1);
        for (int i = 0; i < 65540; i++) begin
            cycle("sat", 1, 0);
            expCnt = (expCnt == 16'hFFFF) ? expCnt : expCnt + 16'd1;
            chk("sat_cnt", {48'd0, stall_count}, {48'd0, expCnt});
            cycle("sat_ld", 0, 1);
        end
        chk("sat_final", {48'd0, stall_count}, 64'h0000_0000_0000_FFFF);

        valid_id = 1'b0; idRec = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("queue_empty", 64'(expQ.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_decode.md
PIPELINE_DECODE -- requirements
Module: pipeline_decode

Interface
REQ-001 Parameter DATA_W, default 64: width of the register operands and the immediate.
REQ-002 Parameter ZERO_REG, default 31: register number that reads as zero; it never causes a hazard.
REQ-003 The module SHALL have one clock, clk, with a synchronous, active-high reset, reset.
REQ-004 Ports (name, direction, width, meaning):
- clk, in, 1: clock; all state updates on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- valid_id, in, 1: the ID stage holds a real instruction.
- MemWrite_id, MemToReg_id, RegDest_id, RegWrite_id, ALUSrc_id, in, 1 each: decoded control bits.
- ALUOp_id, in, 3: ALU operation select.
- Rn_id, Rm_id, Rd_id, in, 5 each: first read address, second read address, write address.
- Da_id, Db_id, Imm_id, in, DATA_W each: register operands and the sign-extended immediate.
- flush, in, 1: squash the instruction entering EX (branch resolved taken).
- valid_ex, out, 1: EX holds a real instruction.
- MemWrite_ex, MemToReg_ex, RegDest_ex, RegWrite_ex, ALUSrc_ex, out, 1 each: registered control bits; they feed the EX/MEM control register.
- ALUOp_ex, out, 3; Rn_ex, Rm_ex, Rd_ex, out, 5 each; Da_ex, Db_ex, Imm_ex, out, DATA_W each: registered copies of the matching ID inputs.
- stall, out, 1: load-use hazard; the PC and IF/ID register must hold this cycle.
- stall_count, out, 16: saturating count of stall cycles.

Function
REQ-005 Every _ex output SHALL be a flop; there is no combinational path from any _id input to any _ex output.
REQ-006 Latency SHALL be one cycle: on a load cycle, the _id values sampled at edge N appear on the _ex outputs after edge N.
REQ-007 The hazard term SHALL be: hz = valid_ex & MemToReg_ex & RegWrite_ex & (Rd_ex != ZERO_REG) & valid_id & ((Rd_ex == Rn_id) | (~ALUSrc_id & (Rd_ex == Rm_id))).
REQ-008 stall SHALL equal hz & ~flush, combinationally from current EX state and the ID inputs.
REQ-009 Each clock edge SHALL take exactly one action, in this priority order:
- reset;
- flush: insert a bubble;
- stall: insert a bubble;
- otherwise: load all _id inputs.
REQ-010 A bubble SHALL clear valid_ex, every control output, ALUOp_ex, and every register-address and data output to 0.
REQ-011 The block SHALL run a two-state FSM, RUN and BUBBLE:
- RUN to BUBBLE on stall;
- BUBBLE to RUN unconditionally on the next edge;
- any state to RUN on flush or reset.
REQ-012 The FSM SHALL NOT assert stall in BUBBLE, because valid_ex=0 there; a load-use hazard therefore costs exactly one stall cycle.
REQ-013 Address comparisons SHALL compare all 5 bits exactly; Rd_ex=ZERO_REG never stalls, even when Rn_id=ZERO_REG.
REQ-014 When valid_id=0, the block SHALL load normally (valid_ex=0, remaining fields copied), and such a slot never stalls.
REQ-015 When flush and hz are both high, stall SHALL be 0 and a bubble SHALL be inserted.
REQ-016 stall_count SHALL increment by 1 on each edge where stall=1 and SHALL saturate at 16'hFFFF without wrapping.

Reset
REQ-017 On an edge with reset=1, every output flop SHALL be set to 0, the FSM SHALL go to RUN, and stall_count SHALL be cleared to 0.
REQ-018 With valid_ex=0 after reset, stall SHALL be 0 in the cycle following reset.
REQ-019 Reset asserted mid-stall SHALL take priority, so no bubble or load occurs on that edge.

Verification
REQ-020 Pass-through: valid_id=1, RegWrite_id=1, Rd_id=5, Da_id=64'h1234, Imm_id=64'hFFFF_FFFF_FFFF_FFF8 -> one edge later valid_ex=1, Rd_ex=5, Da_ex=64'h1234, Imm_ex=64'hFFFF_FFFF_FFFF_FFF8, stall=0.
REQ-021 Load-use: EX holds a load (MemToReg_ex=1, RegWrite_ex=1, Rd_ex=3) and ID has Rn_id=3 -> stall=1 for exactly one cycle, next EX is a bubble (valid_ex=0, all controls 0), the held instruction loads on the following edge, stall_count=1.
REQ-022 Immediate exemption and zero register:
- load Rd_ex=3, ID has ALUSrc_id=1, Rm_id=3, Rn_id=7 -> stall=0;
- load Rd_ex=31, Rn_id=31 -> stall=0.
REQ-023 Flush priority: load-use hazard present with flush=1 -> stall=0, valid_ex=0 next cycle, stall_count unchanged.
REQ-024 Reset mid-operation: reset=1 while the FSM is in BUBBLE and valid data is present on ID -> all outputs 0 next cycle, stall_count=0, FSM in RUN.
REQ-025 Saturation: force 65 540 hazard cycles -> stall_count reaches 16'hFFFF and holds.
